// File: rtl/emboss_stream_filter.sv
// Streaming emboss filter: each output pixel is 128 + (pixel - left neighbour), clamped to 0..255.
// One-word output register with pass-through backpressure; line/frame position tracked for q0 and frame_done.

module emboss_lane #(
    parameter int PW = 8
) (
    input  logic [PW-1:0] pix,
    input  logic [PW-1:0] prev,
    output logic [PW-1:0] q
);
    localparam logic [PW+1:0] BIAS = (PW+2)'(1 << (PW - 1));

    // Two guard bits: range is -127..383, so bit PW+1 flags negative and bit PW flags overflow.
    logic [PW+1:0] sum;

    always_comb begin
        sum = BIAS + {2'b00, pix} - {2'b00, prev};
        if (sum[PW+1])
            q = '0;
        else if (sum[PW])
            q = '1;
        else
            q = sum[PW-1:0];
    end
endmodule

module emboss_stream_filter #(
    parameter int LINE_WORDS  = 80,
    parameter int FRAME_LINES = 480
) (
    input  logic        i_user_clk,
    input  logic        i_rst_n,
    input  logic        i_str_data_valid,
    output logic        o_str_ack,
    input  logic [63:0] i_str_data,
    output logic        o_str_data_valid,
    input  logic        i_str_ack,
    output logic [63:0] o_str_data,
    output logic        o_frame_done
);
    localparam int NUM_LANES = 8;
    localparam int VEC_W     = 8;
    localparam int WW = (LINE_WORDS  > 1) ? $clog2(LINE_WORDS)  : 1;
    localparam int LW = (FRAME_LINES > 1) ? $clog2(FRAME_LINES) : 1;

    logic [NUM_LANES-1:0][VEC_W-1:0] pix, prev, q;
    logic [VEC_W-1:0] last_pix;
    logic [WW-1:0]    word_cnt;
    logic [LW-1:0]    line_cnt;
    logic             in_xfer, word_last, line_last;

    assign o_str_ack = !o_str_data_valid || i_str_ack;
    assign in_xfer   = i_str_data_valid && o_str_ack;
    assign word_last = (word_cnt == WW'(LINE_WORDS - 1));
    assign line_last = (line_cnt == LW'(FRAME_LINES - 1));
    assign pix       = i_str_data;

    // At line start pixel 0 is its own neighbour, so q0 comes out flat (128).
    assign prev[0] = (word_cnt == '0) ? pix[0] : last_pix;

    genvar k;
    generate
        for (k = 1; k < NUM_LANES; k++) begin : g_prev
            assign prev[k] = pix[k-1];
        end
        for (k = 0; k < NUM_LANES; k++) begin : g_lane
            emboss_lane #(.PW(VEC_W)) u_lane (
                .pix  (pix[k]),
                .prev (prev[k]),
                .q    (q[k])
            );
        end
    endgenerate

    always_ff @(posedge i_user_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_str_data_valid <= 1'b0;
            o_str_data       <= '0;
            last_pix         <= '0;
        end else if (in_xfer) begin
            o_str_data_valid <= 1'b1;
            o_str_data       <= q;
            last_pix         <= pix[NUM_LANES-1];
        end else if (i_str_ack) begin
            o_str_data_valid <= 1'b0;
        end
    end

    always_ff @(posedge i_user_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            word_cnt     <= '0;
            line_cnt     <= '0;
            o_frame_done <= 1'b0;
        end else begin
            o_frame_done <= in_xfer && word_last && line_last;
            if (in_xfer) begin
                if (word_last) begin
                    word_cnt <= '0;
                    line_cnt <= line_last ? '0 : line_cnt + 1'b1;
                end else begin
                    word_cnt <= word_cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_emboss_stream_filter.sv
// Directed bench for emboss_stream_filter with a scoreboard fed from accepted inputs.
module tb_emboss_stream_filter;
    localparam int LW = 2;
    localparam int FL = 2;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        in_valid = 1'b0, out_ack = 1'b1;
    logic [63:0] in_data = '0;
    logic        o_str_ack, o_str_data_valid, o_frame_done;
    logic [63:0] o_str_data;

    int errors = 0, checks = 0, fd_count = 0;
    logic [63:0] q_exp[$];
    logic [7:0]  m_prev = '0;
    int          m_wc = 0, m_lc = 0;
    logic        fd_exp = 1'b0;

    emboss_stream_filter #(.LINE_WORDS(LW), .FRAME_LINES(FL)) dut (
        .i_user_clk       (clk),
        .i_rst_n          (rst_n),
        .i_str_data_valid (in_valid),
        .o_str_ack        (o_str_ack),
        .i_str_data       (in_data),
        .o_str_data_valid (o_str_data_valid),
        .i_str_ack        (out_ack),
        .o_str_data       (o_str_data),
        .o_frame_done     (o_frame_done)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [63:0] model(logic [63:0] d, logic first, logic [7:0] pv);
        logic [63:0] r;
        int p, pp, v;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            p = int'(d[8*k +: 8]);
            if (k == 0) pp = first ? p : int'(pv);
            else        pp = int'(d[8*k-8 +: 8]);
            v = 128 + p - pp;
            if (v < 0)   v = 0;
            if (v > 255) v = 255;
            r[8*k +: 8] = 8'(v);
        end
        return r;
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: push on accepted input, pop on output transfer; also tracks frame_done timing.
    always @(negedge clk) begin
        logic nfd;
        if (rst_n) begin
            if (o_str_data_valid && out_ack) begin
                if (q_exp.size() == 0) check("sb_underflow", 64'(q_exp.size()), 64'd1);
                else                   check("sb_data", o_str_data, q_exp.pop_front());
            end
            check("frame_done", 64'(o_frame_done), 64'(fd_exp));
            if (o_frame_done) fd_count++;
            nfd = 1'b0;
            if (in_valid && o_str_ack) begin
                q_exp.push_back(model(in_data, m_wc == 0, m_prev));
                m_prev = in_data[63:56];
                nfd = (m_wc == LW-1) && (m_lc == FL-1);
                if (m_wc == LW-1) begin
                    m_wc = 0;
                    m_lc = (m_lc == FL-1) ? 0 : m_lc + 1;
                end else begin
                    m_wc++;
                end
            end
            fd_exp = nfd;
        end
    end

    task automatic send(logic [63:0] d);
        int n;
        in_valid = 1'b1;
        in_data  = d;
        n = 0;
        @(negedge clk);
        while (!o_str_ack && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!o_str_ack) check("ack_timeout", 64'(o_str_ack), 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic reset_checks(string tag);
        check({tag, "_vld"},  64'(o_str_data_valid), 64'd0);
        check({tag, "_data"}, o_str_data, 64'd0);
        check({tag, "_fd"},   64'(o_frame_done), 64'd0);
        check({tag, "_ack"},  64'(o_str_ack), 64'd1);
    endtask

    initial begin
        #12;
        reset_checks("rst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Frame 1: flat line start, arbitrary word, alternating line start, low-clamp carry.
        send(64'h8080808080808080);
        in_valid = 1'b0;
        @(negedge clk);
        check("flat", o_str_data, 64'h8080808080808080);
        check("flat_vld", 64'(o_str_data_valid), 64'd1);
        @(negedge clk);
        check("vld_clear", 64'(o_str_data_valid), 64'd0);
        @(posedge clk); #1;
        send(64'h00FF102030405060);
        in_valid = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        send(64'hFF00FF00FF00FF00);
        in_valid = 1'b0;
        @(negedge clk);
        check("alt", o_str_data, 64'hFF00FF00FF00FF80);
        @(posedge clk); #1;
        send(64'h0000000000000000);
        in_valid = 1'b0;
        @(negedge clk);
        check("carry", o_str_data, 64'h8080808080808000);
        check("fd_pulse", 64'(o_frame_done), 64'd1);
        @(negedge clk);
        check("fd_single", 64'(o_frame_done), 64'd0);
        @(posedge clk); #1;

        // Backpressure: hold for 3 cycles, then release with no bubble.
        out_ack = 1'b0;
        send(64'h1122334455667788);
        in_data = 64'h2020202020202020;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_ack", 64'(o_str_ack), 64'd0);
            check("hold_vld", 64'(o_str_data_valid), 64'd1);
            check("hold_data", o_str_data, 64'h6F6F6F6F6F6F6F80);
        end
        @(posedge clk); #1;
        out_ack = 1'b1;
        @(negedge clk);
        check("release_ack", 64'(o_str_ack), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("nobubble_vld", 64'(o_str_data_valid), 64'd1);
        check("nobubble_data", o_str_data, 64'h808080808080808F);
        @(posedge clk); #1;

        // Reset mid-frame while a word is held.
        out_ack = 1'b0;
        send(64'h5555555555555555);
        in_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_vld", 64'(o_str_data_valid), 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        reset_checks("midrst");
        q_exp.delete();
        m_prev = '0;
        m_wc = 0;
        m_lc = 0;
        fd_exp = 1'b0;
        @(posedge clk); #1;
        out_ack = 1'b1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Fresh frame: 5 back-to-back words, exactly one frame_done.
        fd_count = 0;
        send(64'h0123456789ABCDEF);
        send(64'hF0E1D2C3B4A59687);
        send(64'h7F7F00FF80017E81);
        send(64'h00000000000000FF);
        send(64'hA5A5A5A5A5A5A5A5);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("fd_count", 64'(fd_count), 64'd1);
        check("sb_empty", 64'(q_exp.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
